// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Purpose:
//   Write-side front end of the 32x32 integer register file. Three result
//   producers share the register file's single synchronous write port:
//     - ALU: fixed latency, no backpressure, always wins the port.
//     - Load unit (mem_*) and divider (div_*): valid/ready handshakes,
//       arbitrated round-robin between themselves when the ALU is idle.
//   Also keeps the pending-write scoreboard used by issue hazard checks. It
//   drives a bypass copy of the registered write for the cycle in which the
//   RAM has not yet committed it. Register r0 is never written.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   alu_valid/dest/data     ALU result (always accepted)
//   mem_valid/dest/data     load result, mem_ready = accepted this cycle
//   div_valid/dest/data     divider result, div_ready = accepted this cycle
//   issue_valid/dest        decode issues an instruction that writes issue_dest
//   pending[31:0]           scoreboard, bit n = write to rn outstanding
//   stall_req               registered request for the pipeline to hold the ALU
//   rf_wren/wraddress/data  register file write port (one cycle after grant)
//   byp_valid/dest/data     bypass copy of the rf_* write
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [4:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [4:0]        div_dest,
    input  logic [DATA_W-1:0] div_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    output logic [31:0]       pending,
    output logic              stall_req,
    output logic              rf_wren,
    output logic [4:0]        rf_wraddress,
    output logic [DATA_W-1:0] rf_data,
    output logic              byp_valid,
    output logic [4:0]        byp_dest,
    output logic [DATA_W-1:0] byp_data
);

    // Identity of the slow source that won the most recent tie.
    localparam logic [0:0] SRC_MEM = 1'b0;
    localparam logic [0:0] SRC_DIV = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // State
    logic              rf_wren_q,      rf_wren_d;
    logic [4:0]        rf_wraddress_q, rf_wraddress_d;
    logic [DATA_W-1:0] rf_data_q,      rf_data_d;
    logic [31:0]       pending_q,      pending_d;
    logic [0:0]        last_grant_q,   last_grant_d;
    logic [CNT_W-1:0]  wait_cnt_q,     wait_cnt_d;
    logic              stall_req_q,    stall_req_d;

    // Grant decode
    logic              alu_grant;
    logic              mem_grant;
    logic              div_grant;
    logic              slow_tie;
    logic              slow_grant;
    logic              wr_sel;
    logic [4:0]        wr_dest;
    logic [DATA_W-1:0] wr_data;

    // Reset dominates: nothing is granted (and so nothing is consumed)
    // while reset is high, so a producer never sees a ready that is then lost.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        div_grant = 1'b0;
        slow_tie  = 1'b0;
        if (!reset) begin
            if (alu_valid) begin
                alu_grant = 1'b1;
            end else if (mem_valid && div_valid) begin
                slow_tie = 1'b1;
                if (last_grant_q == SRC_DIV) begin
                    mem_grant = 1'b1;
                end else begin
                    div_grant = 1'b1;
                end
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end else if (div_valid) begin
                div_grant = 1'b1;
            end
        end
        slow_grant = mem_grant | div_grant;
    end

    assign mem_ready = mem_grant;
    assign div_ready = div_grant;

    // Mux the granted producer onto the write path.
    always_comb begin
        wr_sel  = alu_grant | slow_grant;
        wr_dest = 5'd0;
        wr_data = '0;
        if (alu_grant) begin
            wr_dest = alu_dest;
            wr_data = alu_data;
        end else if (mem_grant) begin
            wr_dest = mem_dest;
            wr_data = mem_data;
        end else if (div_grant) begin
            wr_dest = div_dest;
            wr_data = div_data;
        end
    end

    // Registered write port. Writes to r0 are consumed but never raise
    // rf_wren; address/data hold their last value on idle cycles.
    always_comb begin
        rf_wren_d      = wr_sel && (wr_dest != 5'd0);
        rf_wraddress_d = rf_wraddress_q;
        rf_data_d      = rf_data_q;
        if (wr_sel) begin
            rf_wraddress_d = wr_dest;
            rf_data_d      = wr_data;
        end
    end

    // Scoreboard. Clear first, then set, so an issue to the same register
    // in the cycle its previous write lands keeps the bit outstanding.
    always_comb begin
        pending_d = pending_q;
        if (wr_sel && (wr_dest != 5'd0)) begin
            pending_d[wr_dest] = 1'b0;
        end
        if (issue_valid && (issue_dest != 5'd0)) begin
            pending_d[issue_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Round-robin pointer only moves when both slow sources competed.
    always_comb begin
        last_grant_d = last_grant_q;
        if (slow_tie) begin
            last_grant_d = mem_grant ? SRC_MEM : SRC_DIV;
        end
    end

    // Starvation counter: counts cycles in which a slow result was offered
    // but lost to the ALU. Once it reaches the limit the registered stall
    // keeps the ALU away so a slow source is granted, which clears it again.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (slow_grant) begin
            wait_cnt_d = '0;
        end else if ((mem_valid || div_valid) && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
        stall_req_d = (wait_cnt_d >= CNT_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wren_q      <= 1'b0;
            rf_wraddress_q <= 5'd0;
            rf_data_q      <= '0;
            pending_q      <= '0;
            last_grant_q   <= SRC_DIV;
            wait_cnt_q     <= '0;
            stall_req_q    <= 1'b0;
        end else begin
            rf_wren_q      <= rf_wren_d;
            rf_wraddress_q <= rf_wraddress_d;
            rf_data_q      <= rf_data_d;
            pending_q      <= pending_d;
            last_grant_q   <= last_grant_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_req_q    <= stall_req_d;
        end
    end

    assign rf_wren      = rf_wren_q;
    assign rf_wraddress = rf_wraddress_q;
    assign rf_data      = rf_data_q;
    assign byp_valid    = rf_wren_q;
    assign byp_dest     = rf_wraddress_q;
    assign byp_data     = rf_data_q;
    assign pending      = pending_q;
    assign stall_req    = stall_req_q;

    // The pipeline must not present an ALU result while a stall is requested.
    a_no_alu_during_stall: assert property (
        @(posedge clock) disable iff (reset) !(alu_valid && stall_req_q)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//
// Purpose:
//   Self-checking bench for regfile_writeback: a directed vector table,
//   hand-written starvation and reset sequences, then randomized traffic
//   compared cycle by cycle against a behavioural model of the write port,
//   the scoreboard and the starvation rule.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

    localparam int WIN_NONE = 0;
    localparam int WIN_ALU  = 1;
    localparam int WIN_MEM  = 2;
    localparam int WIN_DIV  = 3;
    localparam int LIMIT    = 4;
    localparam int SAT      = 7;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dest;
    logic [31:0] mem_data;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_dest;
    logic [31:0] div_data;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [31:0] pending;
    logic        stall_req;
    logic        rf_wren;
    logic [4:0]  rf_wraddress;
    logic [31:0] rf_data;
    logic        byp_valid;
    logic [4:0]  byp_dest;
    logic [31:0] byp_data;

    regfile_writeback #(.STARVE_LIMIT(4), .CNT_W(3), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .div_valid(div_valid), .div_ready(div_ready), .div_dest(div_dest), .div_data(div_data),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .pending(pending), .stall_req(stall_req),
        .rf_wren(rf_wren), .rf_wraddress(rf_wraddress), .rf_data(rf_data),
        .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_data(byp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pend;
    logic        m_last_div;
    int          m_wait;
    logic        m_stall;
    logic        m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          w;

    typedef struct {
        logic        alu_v; logic [4:0] alu_d; logic [31:0] alu_x;
        logic        mem_v; logic [4:0] mem_d; logic [31:0] mem_x;
        logic        div_v; logic [4:0] div_d; logic [31:0] div_x;
        logic        iss_v; logic [4:0] iss_d;
        logic        e_mrdy; logic e_drdy; logic e_wren;
        logic [4:0]  e_addr; logic [31:0] e_data; logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ad, input logic [31:0] ax,
        input logic mv, input logic [4:0] md, input logic [31:0] mx,
        input logic dv, input logic [4:0] dd, input logic [31:0] dx,
        input logic iv, input logic [4:0] id,
        input logic emr, input logic edr, input logic ew,
        input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] ep);
        vec_t v;
        v.alu_v = av; v.alu_d = ad; v.alu_x = ax;
        v.mem_v = mv; v.mem_d = md; v.mem_x = mx;
        v.div_v = dv; v.div_d = dd; v.div_x = dx;
        v.iss_v = iv; v.iss_d = id;
        v.e_mrdy = emr; v.e_drdy = edr; v.e_wren = ew;
        v.e_addr = ea; v.e_data = ed; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_dest = 5'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_dest = 5'd0; mem_data = 32'h0;
        div_valid = 1'b0; div_dest = 5'd0; div_data = 32'h0;
        issue_valid = 1'b0; issue_dest = 5'd0;
    endtask

    // Called just after a falling edge with inputs already driven: predicts
    // the winner, then checks the combinational ready outputs.
    task automatic phase_comb();
        w = WIN_NONE;
        if (!reset) begin
            if (alu_valid)                   w = WIN_ALU;
            else if (mem_valid && div_valid) w = m_last_div ? WIN_MEM : WIN_DIV;
            else if (mem_valid)              w = WIN_MEM;
            else if (div_valid)              w = WIN_DIV;
        end
        #1;
        chk("mem_ready", 32'(mem_ready), 32'(w == WIN_MEM));
        chk("div_ready", 32'(div_ready), 32'(w == WIN_DIV));
    endtask

    // Advances the model across the rising edge and checks registered outputs.
    task automatic phase_seq();
        int          dst;
        logic [31:0] dat;
        dst = -1;
        dat = 32'h0;
        if (reset) begin
            m_pend = 32'h0; m_last_div = 1'b1; m_wait = 0; m_stall = 1'b0; m_wren = 1'b0;
        end else begin
            if (w == WIN_ALU) begin dst = int'(alu_dest); dat = alu_data; end
            if (w == WIN_MEM) begin dst = int'(mem_dest); dat = mem_data; end
            if (w == WIN_DIV) begin dst = int'(div_dest); dat = div_data; end
            m_wren = (dst > 0);
            if (dst > 0) begin
                m_addr = 5'(dst);
                m_data = dat;
                m_pend[dst] = 1'b0;
            end
            if (issue_valid && issue_dest != 5'd0) m_pend[issue_dest] = 1'b1;
            if (mem_valid && div_valid && (w == WIN_MEM || w == WIN_DIV))
                m_last_div = (w == WIN_DIV);
            if (w == WIN_MEM || w == WIN_DIV) m_wait = 0;
            else if (mem_valid || div_valid) m_wait = (m_wait + 1 > SAT) ? SAT : m_wait + 1;
            m_stall = (m_wait >= LIMIT);
        end
        @(negedge clock);
        chk("rf_wren", 32'(rf_wren), 32'(m_wren));
        chk("byp_valid", 32'(byp_valid), 32'(m_wren));
        if (m_wren) begin
            chk("rf_wraddress", 32'(rf_wraddress), 32'(m_addr));
            chk("rf_data", rf_data, m_data);
            chk("byp_dest", 32'(byp_dest), 32'(m_addr));
            chk("byp_data", byp_data, m_data);
        end
        chk("pending", pending, m_pend);
        chk("stall_req", 32'(stall_req), 32'(m_stall));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        phase_comb();
        phase_seq();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_pend = 32'h0; m_last_div = 1'b1; m_wait = 0; m_stall = 1'b0;
        m_wren = 1'b0; m_addr = 5'd0; m_data = 32'h0; w = WIN_NONE;
        @(negedge clock);
        do_reset();
        chk("reset_rf_wraddress", 32'(rf_wraddress), 32'h0);
        chk("reset_rf_data", rf_data, 32'h0);

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(1'b1,5'd5,32'h1234,     1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b0,1'b0,1'b1,5'd5,32'h1234,32'h0);
        tbl[1]  = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b0,1'b0,1'b0,5'd0,32'h0,32'h0);
        tbl[2]  = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd7,  1'b0,1'b0,1'b0,5'd0,32'h0,32'h80);
        tbl[3]  = mk(1'b0,5'd0,32'h0,        1'b1,5'd7,32'hAAAA,  1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b1,1'b0,1'b1,5'd7,32'hAAAA,32'h0);
        tbl[4]  = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd7,  1'b0,1'b0,1'b0,5'd0,32'h0,32'h80);
        tbl[5]  = mk(1'b0,5'd0,32'h0,        1'b1,5'd7,32'h5555,  1'b0,5'd0,32'h0,     1'b1,5'd7,  1'b1,1'b0,1'b1,5'd7,32'h5555,32'h80);
        tbl[6]  = mk(1'b0,5'd0,32'h0,        1'b1,5'd3,32'h3333,  1'b1,5'd4,32'h4444,  1'b0,5'd0,  1'b1,1'b0,1'b1,5'd3,32'h3333,32'h80);
        tbl[7]  = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,5'd4,32'h4444,  1'b0,5'd0,  1'b0,1'b1,1'b1,5'd4,32'h4444,32'h80);
        tbl[8]  = mk(1'b0,5'd0,32'h0,        1'b1,5'd9,32'h9999,  1'b1,5'd10,32'hAAA0, 1'b0,5'd0,  1'b0,1'b1,1'b1,5'd10,32'hAAA0,32'h80);
        tbl[9]  = mk(1'b0,5'd0,32'h0,        1'b1,5'd9,32'h9999,  1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b1,1'b0,1'b1,5'd9,32'h9999,32'h80);
        tbl[10] = mk(1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b0,1'b0,1'b0,5'd0,32'h0,32'h80);
        tbl[11] = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,5'd0,32'h1,     1'b0,5'd0,  1'b0,1'b1,1'b0,5'd0,32'h0,32'h80);
        tbl[12] = mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd0,  1'b0,1'b0,1'b0,5'd0,32'h0,32'h80);
        tbl[13] = mk(1'b0,5'd0,32'h0,        1'b1,5'd7,32'h7777,  1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b1,1'b0,1'b1,5'd7,32'h7777,32'h0);
        tbl[14] = mk(1'b1,5'd31,32'hDEADBEEF,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b1,5'd31, 1'b0,1'b0,1'b1,5'd31,32'hDEADBEEF,32'h80000000);
        tbl[15] = mk(1'b1,5'd31,32'hCAFEF00D,1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b0,1'b0,1'b1,5'd31,32'hCAFEF00D,32'h0);
        tbl[16] = mk(1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b0,1'b0,1'b1,5'd1,32'h11,32'h0);
        tbl[17] = mk(1'b0,5'd0,32'h0,        1'b1,5'd2,32'h22,    1'b0,5'd0,32'h0,     1'b0,5'd0,  1'b1,1'b0,1'b1,5'd2,32'h22,32'h0);

        for (int i = 0; i < 18; i++) begin
            alu_valid = tbl[i].alu_v; alu_dest = tbl[i].alu_d; alu_data = tbl[i].alu_x;
            mem_valid = tbl[i].mem_v; mem_dest = tbl[i].mem_d; mem_data = tbl[i].mem_x;
            div_valid = tbl[i].div_v; div_dest = tbl[i].div_d; div_data = tbl[i].div_x;
            issue_valid = tbl[i].iss_v; issue_dest = tbl[i].iss_d;
            phase_comb();
            chk($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mrdy));
            chk($sformatf("tbl%0d_div_ready", i), 32'(div_ready), 32'(tbl[i].e_drdy));
            phase_seq();
            chk($sformatf("tbl%0d_rf_wren", i), 32'(rf_wren), 32'(tbl[i].e_wren));
            if (tbl[i].e_wren) begin
                chk($sformatf("tbl%0d_rf_wraddress", i), 32'(rf_wraddress), 32'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_rf_data", i), rf_data, tbl[i].e_data);
            end
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
        end
        idle_inputs();

        // ---------------- starvation: ALU every cycle, load held ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'(i);
            mem_valid = 1'b1; mem_dest = 5'd6; mem_data = 32'h66;
            phase_comb();
            chk("starve_mem_ready_low", 32'(mem_ready), 32'h0);
            phase_seq();
            chk($sformatf("starve_stall_%0d", i), 32'(stall_req), 32'(i == 3));
        end
        alu_valid = 1'b0;
        phase_comb();
        chk("starve_mem_granted", 32'(mem_ready), 32'h1);
        phase_seq();
        chk("starve_stall_fall", 32'(stall_req), 32'h0);
        chk("starve_write_addr", 32'(rf_wraddress), 32'h6);
        idle_inputs();

        // ---------------- reset the cycle after a grant ----------------
        do_reset();
        issue_valid = 1'b1; issue_dest = 5'd7;
        phase_comb();
        phase_seq();
        chk("rst_seq_pend_set", pending, 32'h80);
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_dest = 5'd8; mem_data = 32'h88;
        phase_comb();
        phase_seq();
        chk("rst_seq_wren_before", 32'(rf_wren), 32'h1);
        chk("rst_seq_pend_before", pending, 32'h80);
        mem_valid = 1'b0;
        reset = 1'b1;
        phase_comb();
        phase_seq();
        chk("rst_seq_wren_cancel", 32'(rf_wren), 32'h0);
        chk("rst_seq_pend_clear", pending, 32'h0);
        reset = 1'b0;
        mem_valid = 1'b1; mem_dest = 5'd3; mem_data = 32'h33;
        div_valid = 1'b1; div_dest = 5'd4; div_data = 32'h44;
        phase_comb();
        chk("rst_seq_mem_first", 32'(mem_ready), 32'h1);
        chk("rst_seq_div_waits", 32'(div_ready), 32'h0);
        phase_seq();
        idle_inputs();

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!mem_valid || w == WIN_MEM || $urandom_range(0, 9) == 0) begin
                mem_valid = ($urandom_range(0, 1) == 1);
                mem_dest  = 5'($urandom);
                mem_data  = $urandom;
            end
            if (!div_valid || w == WIN_DIV || $urandom_range(0, 9) == 0) begin
                div_valid = ($urandom_range(0, 2) == 0);
                div_dest  = 5'($urandom);
                div_data  = $urandom;
            end
            alu_valid   = !m_stall && ($urandom_range(0, 9) < 6);
            alu_dest    = 5'($urandom);
            alu_data    = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_dest  = 5'($urandom);
            reset       = ($urandom_range(0, 199) == 0);
            phase_comb();
            phase_seq();
        end
        reset = 1'b0;
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
